// File: rtl/bist_seq_controller_if.sv
// Handshake/result bundle between the test top-level and bist_seq_controller.
// The test top-level drives the master side; the sequencer owns the slave side.
interface bist_seq_controller_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int SIG_W  = 16
);
  localparam int CH_W = $clog2(NUM_CH) + 1;

  logic                    start;
  logic                    abort;
  logic [CNT_W-1:0]        cycles;
  logic [NUM_CH-1:0]       ch_mask;
  logic [NUM_CH*SIG_W-1:0] sig_in;
  logic [NUM_CH*SIG_W-1:0] golden;
  logic                    ack;

  logic                    busy;
  logic [CH_W-1:0]         ch_sel;
  logic [NUM_CH-1:0]       init;
  logic                    running;
  logic                    toggle;
  logic                    finish;
  logic                    bist_end;
  logic                    pass;
  logic [NUM_CH-1:0]       fail_map;
  logic                    aborted;
  logic                    timed_out;

  modport master (
    output start, abort, cycles, ch_mask, sig_in, golden, ack,
    input  busy, ch_sel, init, running, toggle, finish, bist_end,
           pass, fail_map, aborted, timed_out
  );

  modport slave (
    input  start, abort, cycles, ch_mask, sig_in, golden, ack,
    output busy, ch_sel, init, running, toggle, finish, bist_end,
           pass, fail_map, aborted, timed_out
  );
endinterface

// File: rtl/bist_seq_controller.sv
// Multi-channel BIST sequencer: walks enabled channels in ascending order
// (init, run, finish, compare) and reports pass/fail. BIST_TIMEOUT_EN adds an END ack watchdog.
module bist_seq_controller #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int SIG_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  bist_seq_controller_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_INIT, S_RUN, S_FINISH, S_CMP, S_END
  } state_e;

  state_e            state_q, state_d;
  logic              armed_q, armed_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [CNT_W-1:0]  ncnt_q, ncnt_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [NUM_CH-1:0] fail_q, fail_d;
  logic              abrt_q, abrt_d;
  logic              pass_q, pass_d;
  logic              tmo_q, tmo_d;
  logic              accept;
  logic              wd_expire;

  logic [NUM_CH-1:0] mism;
  logic [NUM_CH-1:0] ch_oh;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cmp
    assign mism[gi] = bus.sig_in[gi*SIG_W +: SIG_W] != bus.golden[gi*SIG_W +: SIG_W];
  end

  assign ch_oh = NUM_CH'(1) << ch_q;

  // low_ch: first channel of the incoming mask; next_ch: next enabled channel above ch_q
  logic [CH_W-1:0] low_ch, next_ch;
  logic            next_vld;
  always_comb begin
    low_ch   = '0;
    next_ch  = '0;
    next_vld = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.ch_mask[i]) low_ch = CH_W'(i);
      if (mask_q[i] && (CH_W'(i) > ch_q)) begin
        next_ch  = CH_W'(i);
        next_vld = 1'b1;
      end
    end
  end

`ifdef BIST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                wd_q <= '0;
    else if (state_q == S_END)  wd_q <= wd_q + WD_W'(1);
    else                        wd_q <= '0;
  end
  assign wd_expire = (state_q == S_END) && (wd_q == WD_W'(TIMEOUT - 1));
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    cycles_d = cycles_q;
    ncnt_d   = ncnt_q;
    mask_d   = mask_q;
    ch_d     = ch_q;
    fail_d   = fail_q;
    abrt_d   = abrt_q;
    pass_d   = pass_q;
    tmo_d    = tmo_q;
    accept   = (state_q == S_IDLE) && bus.start && armed_q;

    if (!bus.start)  armed_d = 1'b1;
    else if (accept) armed_d = 1'b0;

    case (state_q)
      S_IDLE: if (accept) begin
        cycles_d = bus.cycles;
        mask_d   = bus.ch_mask;
        ch_d     = low_ch;
        fail_d   = '0;
        abrt_d   = 1'b0;
        tmo_d    = 1'b0;
        pass_d   = 1'b0;
        state_d  = S_START;
      end
      S_START: state_d = (mask_q == '0) ? S_END : S_INIT;
      S_INIT: begin
        ncnt_d  = '0;
        state_d = (cycles_q == '0) ? S_FINISH : S_RUN;
      end
      S_RUN: begin
        if (ncnt_q == cycles_q - CNT_W'(1)) state_d = S_FINISH;
        else                                ncnt_d  = ncnt_q + CNT_W'(1);
      end
      S_FINISH: state_d = S_CMP;
      S_CMP: begin
        fail_d = fail_q | (ch_oh & mism);
        if (next_vld) begin
          ch_d    = next_ch;
          state_d = S_INIT;
        end else begin
          state_d = S_END;
        end
      end
      S_END: begin
        if (bus.ack) state_d = S_IDLE;
        else if (wd_expire) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything mid-test, including the compare of the current channel.
    if (bus.abort && (state_q != S_IDLE) && (state_q != S_END)) begin
      state_d = S_END;
      abrt_d  = 1'b1;
      fail_d  = fail_q;
      ch_d    = ch_q;
    end

    if ((state_d == S_END) && (state_q != S_END))
      pass_d = (fail_d == '0) && !abrt_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      armed_q  <= 1'b1;
      cycles_q <= '0;
      ncnt_q   <= '0;
      mask_q   <= '0;
      ch_q     <= '0;
      fail_q   <= '0;
      abrt_q   <= 1'b0;
      pass_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      cycles_q <= cycles_d;
      ncnt_q   <= ncnt_d;
      mask_q   <= mask_d;
      ch_q     <= ch_d;
      fail_q   <= fail_d;
      abrt_q   <= abrt_d;
      pass_q   <= pass_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.ch_sel    = ch_q;
  assign bus.init      = (state_q == S_INIT) ? ch_oh : '0;
  assign bus.running   = (state_q == S_RUN);
  assign bus.toggle    = (state_q == S_RUN) && !ncnt_q[0];
  assign bus.finish    = (state_q == S_FINISH);
  assign bus.bist_end  = (state_q == S_END);
  assign bus.pass      = pass_q;
  assign bus.fail_map  = fail_q;
  assign bus.aborted   = abrt_q;
  assign bus.timed_out = tmo_q;
endmodule

// File: tb/tb_bist_seq_controller.sv
// Randomized bench for bist_seq_controller: a per-cycle expected trace is built
// from the channel-walk rules and compared against the DUT outputs.
module tb_bist_seq_controller;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int SIG_W  = 16;
  localparam int NO_ABORT = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bist_seq_controller_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SIG_W(SIG_W)) bus ();

  bist_seq_controller #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SIG_W(SIG_W), .TIMEOUT(16)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [11:0] v;
    int          cmp_ch;
  } ent_t;

  ent_t tr[$];

  function automatic logic [11:0] pk(input logic b, input int ch, input logic [3:0] in,
                                     input logic r, input logic t, input logic f, input logic e);
    return {b, 3'(ch), in, r, t, f, e};
  endfunction

  function automatic logic [11:0] obs();
    return {bus.busy, bus.ch_sel, bus.init, bus.running, bus.toggle, bus.finish, bus.bist_end};
  endfunction

  function automatic int lowest(input logic [3:0] m);
    int r = 0;
    for (int i = 3; i >= 0; i--) if (m[i]) r = i;
    return r;
  endfunction

  task automatic push(input logic [11:0] v, input int c);
    ent_t e;
    e.v = v;
    e.cmp_ch = c;
    tr.push_back(e);
  endtask

  task automatic run_test(input logic [3:0] mask, input int cyc, input logic [3:0] mism,
                          input int abort_at, input int end_wait);
    logic [63:0] g, s;
    logic [3:0]  exp_fail;
    logic        exp_abrt, exp_pass;
    int          last, ch_end;

    tr.delete();
    push(pk(1, lowest(mask), 4'b0, 0, 0, 0, 0), -1);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        push(pk(1, i, 4'(1 << i), 0, 0, 0, 0), -1);
        for (int k = 0; k < cyc; k++) push(pk(1, i, 4'b0, 1, (k % 2) == 0, 0, 0), -1);
        push(pk(1, i, 4'b0, 0, 0, 1, 0), -1);
        push(pk(1, i, 4'b0, 0, 0, 0, 0), i);
      end
    end
    exp_abrt = abort_at < tr.size();
    last     = exp_abrt ? abort_at : tr.size() - 1;
    exp_fail = '0;
    for (int k = 0; k < tr.size(); k++)
      if (k < abort_at && tr[k].cmp_ch >= 0 && mism[tr[k].cmp_ch]) exp_fail[tr[k].cmp_ch] = 1'b1;
    exp_pass = (exp_fail == '0) && !exp_abrt;
    ch_end   = int'(tr[last].v[10:8]);

    for (int i = 0; i < 4; i++) begin
      g[i*16 +: 16] = 16'($urandom);
      s[i*16 +: 16] = g[i*16 +: 16] ^ (mism[i] ? 16'(1 << $urandom_range(0, 15)) : 16'h0);
    end

    @(negedge clk);
    bus.ch_mask = mask;
    bus.cycles  = 16'(cyc);
    bus.golden  = g;
    bus.sig_in  = s;
    bus.start   = 1'b1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      bus.abort = 1'b0;
      chk("trace", 64'(obs()), 64'(tr[k].v));
      if (k == abort_at) bus.abort = 1'b1;
    end
    for (int w = 0; w <= end_wait; w++) begin
      @(negedge clk);
      bus.abort = w[0];  // abort in END must be ignored
      chk("end_state", 64'(obs()), 64'(pk(1, ch_end, 4'b0, 0, 0, 0, 1)));
      chk("pass", 64'(bus.pass), 64'(exp_pass));
      chk("fail_map", 64'(bus.fail_map), 64'(exp_fail));
      chk("aborted", 64'(bus.aborted), 64'(exp_abrt));
      chk("timed_out", 64'(bus.timed_out), 64'(0));
    end
    bus.abort = 1'b0;
    bus.ack   = 1'b1;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      chk("idle_hold", 64'(obs()), 64'(pk(0, ch_end, 4'b0, 0, 0, 0, 0)));
      chk("idle_fail", 64'({bus.pass, bus.aborted, bus.fail_map}), 64'({exp_pass, exp_abrt, exp_fail}));
    end
    bus.ack   = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.ack = 1'b0;
    bus.cycles = '0; bus.ch_mask = '0; bus.sig_in = '0; bus.golden = '0;
    #1;
    chk("reset_obs", 64'(obs()), 64'(0));
    chk("reset_res", 64'({bus.pass, bus.aborted, bus.timed_out, bus.fail_map}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_test(4'b0001, 5, 4'b0000, NO_ABORT, 2);
    run_test(4'b1010, 3, 4'b1000, NO_ABORT, 1);
    run_test(4'b0001, 0, 4'b0000, NO_ABORT, 0);
    run_test(4'b0000, 4, 4'b1111, NO_ABORT, 1);
    run_test(4'b0001, 5, 4'b0000, 3, 2);
    run_test(4'b1111, 2, 4'b0101, NO_ABORT, 0);
    run_test(4'b0110, 1, 4'b0110, 0, 0);

    for (int t = 0; t < 24; t++)
      run_test(4'($urandom), $urandom_range(0, 6), 4'($urandom),
               ($urandom_range(0, 2) == 0) ? $urandom_range(0, 25) : NO_ABORT,
               $urandom_range(0, 3));

    // Asynchronous reset mid-RUNNING, with start held through reset.
    @(negedge clk);
    bus.ch_mask = 4'b0001; bus.cycles = 16'd10; bus.start = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_reset_run", 64'(bus.running), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_obs", 64'(obs()), 64'(0));
    chk("async_rst_res", 64'({bus.pass, bus.aborted, bus.timed_out, bus.fail_map}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_after_rst", 64'(obs()), 64'(pk(1, 0, 4'b0, 0, 0, 0, 0)));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("rst_abort_end", 64'({bus.bist_end, bus.aborted, bus.pass}), 64'(3'b110));
    bus.ack = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    bus.ack = 1'b0;
    chk("rst_abort_idle", 64'(bus.busy), 64'(0));

    // END watchdog.
    @(negedge clk);
    bus.ch_mask = 4'b0000; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
`ifdef BIST_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("wd_end", 64'(bus.bist_end), 64'(1));
    end
    @(negedge clk);
    chk("wd_expired", 64'({bus.busy, bus.timed_out}), 64'(2'b01));
`else
    for (int k = 0; k < 40; k++) @(negedge clk);
    chk("no_wd", 64'({bus.bist_end, bus.timed_out}), 64'(2'b10));
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    chk("no_wd_idle", 64'(bus.busy), 64'(0));
`endif
    run_test(4'b0100, 2, 4'b0000, NO_ABORT, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/bist_seq_controller.md
Name: bist_seq_controller

Overview:
- Parametrised multi-channel BIST sequencer, successor to the single-channel fixed-count BIST controller.
- Walks up to NUM_CH test channels in ascending index order. For each enabled channel: init pulse, runtime-programmable count of RUNNING cycles with toggle stimulus, finish pulse, then signature compare against golden.
- Ends with a bist_end/ack handshake carrying pass/fail results.
- Sits between the test top-level and the per-channel pattern generators/MISRs.

Parameters:
- NUM_CH, 4, number of test channels (1..16)
- CNT_W, 16, width of the run-length counter and cycles input
- SIG_W, 16, width of each channel's signature
- TIMEOUT, 1024, END-state ack watchdog limit in cycles (used only with BIST_TIMEOUT_EN)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  level request; edge-qualified internally
- abort  in  1  abandon the current test
- cycles  in  CNT_W  RUNNING length per channel; latched when start is accepted
- ch_mask  in  NUM_CH  enabled channels; latched when start is accepted
- sig_in  in  NUM_CH*SIG_W  channel signatures; slice i belongs to channel i
- golden  in  NUM_CH*SIG_W  expected signatures, same slicing as sig_in
- ack  in  1  consumer has read the results
- busy  out  1  state != IDLE
- ch_sel  out  $clog2(NUM_CH)+1  current channel index
- init  out  NUM_CH  one-hot, high for one cycle in INIT
- running  out  1  high in RUNNING
- toggle  out  1  stimulus toggle, valid only while running
- finish  out  1  one-cycle pulse in FINISH
- bist_end  out  1  results valid; held until ack
- pass  out  1  all enabled channels matched and no abort
- fail_map  out  NUM_CH  bit i = channel i mismatched
- aborted  out  1  test was aborted
- timed_out  out  1  END ack watchdog expired

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0 (fail_map, aborted, timed_out cleared). armed=1.
- Start acceptance: in IDLE, a posedge with start=1 and armed=1 accepts the request. It latches cycles and ch_mask, clears fail_map/aborted/timed_out, sets armed=0 and moves to START. armed returns to 1 on any posedge with start=0. Holding start high never retriggers a test.
- States: IDLE, START, INIT, RUNNING, FINISH, COMPARE, END.
- START (1 cycle): ch_sel = lowest set bit of the latched mask. If the mask is 0, go straight to END with pass=1.
- INIT (1 cycle): init[ch_sel]=1. Next state is RUNNING, or FINISH if the latched cycles == 0.
- RUNNING: lasts exactly cycles_q cycles. ncounter runs 0..cycles_q-1 and the state exits when ncounter == cycles_q-1. toggle=1 on RUNNING cycles 0,2,4,... and 0 on odd cycles. ncounter is CNT_W wide and unsigned; cycles=2^CNT_W-1 is legal and produces no wrap.
- FINISH (1 cycle): finish=1.
- COMPARE (1 cycle): fail_map[ch_sel] |= (sig_in slice != golden slice). Next is INIT for the next higher enabled channel (ch_sel updated), else END.
- END: bist_end=1, pass=(fail_map==0)&!aborted. Both hold until a posedge with ack=1, then the next state is IDLE. fail_map, pass and aborted stay readable in IDLE until the next accepted start.
- Latency, single channel, cycles=N: start accepted at T; START at T+1; INIT at T+2; RUNNING T+3..T+2+N; FINISH T+3+N; COMPARE T+4+N; bist_end at T+5+N.
- Abort: abort=1 in START/INIT/RUNNING/FINISH/COMPARE sets aborted=1 and moves to END next cycle. No finish pulse and no further compares. abort is ignored in IDLE and END. abort takes priority over all other transitions.
- Simultaneous ack and start in END: ack is honoured and the state returns to IDLE. start is evaluated only from IDLE, and only if armed.
- Reset mid-operation: immediate return to IDLE and all outputs 0. A start held high through reset is accepted on the first posedge after reset is released (armed=1).

Optional Feature:
- Macro BIST_TIMEOUT_EN.
- Defined: a watchdog counts cycles in END. If it reaches TIMEOUT without ack, it sets timed_out=1 and the state returns to IDLE. timed_out stays 1 until the next accepted start or reset.
- Undefined: no watchdog; END waits indefinitely; timed_out is tied to 0.

Test Plan:
- ch_mask=4'b0001, cycles=5, matching signature -> running high 5 cycles, toggle pattern 1,0,1,0,1; finish at T+8; bist_end at T+10; pass=1; fail_map=0.
- ch_mask=4'b1010, cycles=3, channel 3 signature mismatched -> init pulses on bit1 then bit3; ch_sel sequence 1,3; fail_map=4'b1000; pass=0.
- cycles=0, ch_mask=4'b0001 -> INIT then FINISH directly, running never asserted; ch_mask=0 -> END at T+2 with pass=1.
- abort asserted on the 2nd RUNNING cycle of channel 0 -> no finish pulse, aborted=1, pass=0, bist_end held; ack returns to IDLE; start held high afterwards does not restart until start is dropped and raised again.
- reset pulled low mid-RUNNING -> all outputs 0 asynchronously; with BIST_TIMEOUT_EN and TIMEOUT=16, ack never asserted -> timed_out=1 after 16 END cycles and busy drops to 0.
